tdm_demux: RTL and testbench

- Receive-side partner of the mux_4x1 serializer.
- A transmitter scans a 4:1 mux with a free-running select and sends one channel slot per valid beat.
- This block locks onto frame sync, steers each slot to its channel register, and publishes a complete parallel frame with a one-cycle valid strobe.
- Sits between the serial link and the channel consumers.

---
 rtl/tdm_demux_if.sv | 55 +++++
 rtl/tdm_demux.sv | 153 +++++++++++++++
 tb/tb_tdm_demux.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_if
// Groups the serial link inputs and the parallel frame outputs of the TDM
// receive-side demultiplexer into one bundle.
//
//   din         serial slot data (DATA_W bits)
//   din_valid   a slot is present on din this cycle
//   frame_sync  marks slot 0 of a frame (qualified by din_valid)
//   dout        last committed frame, channel k at [k*DATA_W +: DATA_W]
//   dout_valid  one-cycle pulse when dout updates
//   slot        index of the next expected slot
//   locked      high while the receiver is framed
//   sync_err    one-cycle pulse on a framing violation
//   din_par     even parity over din      (only with TDM_PARITY_EN)
//   par_err     one-cycle pulse on a dropped, corrupted frame (TDM_PARITY_EN)
//
// Modports: slave = the demultiplexer, master = whoever drives the link and
// consumes the frames.
// ---------------------------------------------------------------------------
interface tdm_demux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
);
    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     frame_sync;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     dout_valid;
    logic [SEL_W-1:0]         slot;
    logic                     locked;
    logic                     sync_err;
`ifdef TDM_PARITY_EN
    logic                     din_par;
    logic                     par_err;
`endif

    modport slave (
        input  din, din_valid, frame_sync,
`ifdef TDM_PARITY_EN
        input  din_par,
        output par_err,
`endif
        output dout, dout_valid, slot, locked, sync_err
    );

    modport master (
        output din, din_valid, frame_sync,
`ifdef TDM_PARITY_EN
        output din_par,
        input  par_err,
`endif
        input  dout, dout_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
// Receive-side partner of the mux_4x1 serializer. Locks onto frame sync,
// steers every valid slot into a shadow register and publishes the whole
// frame on dout at once, together with a one-cycle dout_valid strobe.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   tdm_demux_if.slave (din/din_valid/frame_sync in,
//         dout/dout_valid/slot/locked/sync_err out)
//
// Optional feature macro: TDM_PARITY_EN
//   Adds din_par / par_err. A frame with any beat whose even parity is wrong
//   is not committed; par_err pulses at its last slot instead.
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
) (
    input logic         clk,
    input logic         rst,
    tdm_demux_if.slave  bus
);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    logic [0:0]               state_q, state_d;
    logic [SEL_W-1:0]         slot_q, slot_d;
    logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0] dout_q, dout_d;
    logic                     doutValid_q, doutValid_d;
    logic                     syncErr_q, syncErr_d;

`ifdef TDM_PARITY_EN
    // Sticky "this frame saw a bad beat" flag; restarted by every slot-0 beat.
    logic frameBad_q, frameBad_d;
    logic parErr_q, parErr_d;
    logic parBad;

    assign parBad = (bus.din_par != (^bus.din));
`endif

    // Next-state logic. Idle cycles (din_valid low) hold everything and let
    // the one-cycle strobes fall. Slot 0 is always written in the low field
    // of the shadow, whether it arrives from HUNT or as an early re-sync.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        dout_d      = dout_q;
        doutValid_d = 1'b0;
        syncErr_d   = 1'b0;
`ifdef TDM_PARITY_EN
        frameBad_d  = frameBad_q;
        parErr_d    = 1'b0;
`endif
        if (bus.din_valid) begin
            if (state_q == HUNT) begin
                if (bus.frame_sync) begin
                    shadow_d[DATA_W-1:0] = bus.din;
                    slot_d               = SLOT_ONE;
                    state_d              = RUN;
`ifdef TDM_PARITY_EN
                    frameBad_d           = parBad;
`endif
                end
            end else if (bus.frame_sync && (slot_q != '0)) begin
                // Early sync: abandon the partial frame and restart at slot 0.
                syncErr_d            = 1'b1;
                shadow_d[DATA_W-1:0] = bus.din;
                slot_d               = SLOT_ONE;
`ifdef TDM_PARITY_EN
                frameBad_d           = parBad;
`endif
            end else if (!bus.frame_sync && (slot_q == '0)) begin
                // Missing sync: framing is lost, the beat is thrown away.
                syncErr_d = 1'b1;
                slot_d    = '0;
                state_d   = HUNT;
            end else begin
                shadow_d[int'(slot_q)*DATA_W +: DATA_W] = bus.din;
`ifdef TDM_PARITY_EN
                frameBad_d = (slot_q == '0) ? parBad : (frameBad_q | parBad);
`endif
                if (slot_q == LAST_SLOT) begin
                    // The commit uses the freshly written shadow so the last
                    // slot lands in dout on the same edge it is accepted.
                    slot_d = '0;
`ifdef TDM_PARITY_EN
                    if (frameBad_d) begin
                        parErr_d = 1'b1;
                    end else begin
                        dout_d      = shadow_d;
                        doutValid_d = 1'b1;
                    end
`else
                    dout_d      = shadow_d;
                    doutValid_d = 1'b1;
`endif
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            syncErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            syncErr_q   <= syncErr_d;
        end
    end

`ifdef TDM_PARITY_EN
    // Parity tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frameBad_q <= 1'b0;
            parErr_q   <= 1'b0;
        end else begin
            frameBad_q <= frameBad_d;
            parErr_q   <= parErr_d;
        end
    end

    assign bus.par_err = parErr_q;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = doutValid_q;
    assign bus.slot       = slot_q;
    assign bus.locked     = (state_q == RUN);
    assign bus.sync_err   = syncErr_q;

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
// Directed bench for tdm_demux with NUM_CH=4, DATA_W=1. Walks through
// normal frames, idle gaps, hunting, early and missing sync, a mid-frame
// reset and (with TDM_PARITY_EN) a parity-corrupted frame.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    logic clk;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    logic parFlip   = 1'b0;
    logic expParErr = 1'b0;

    tdm_demux_if #(.NUM_CH(4), .DATA_W(1), .SEL_W(2)) bus ();

    tdm_demux #(.NUM_CH(4), .DATA_W(1), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of link inputs, then step just past the rising edge.
    task automatic applyStimulus(input logic valid, input logic fs, input logic d);
        bus.din_valid  = valid;
        bus.frame_sync = fs;
        bus.din        = d;
`ifdef TDM_PARITY_EN
        bus.din_par    = d ^ parFlip;
`endif
        @(posedge clk);
        #1;
    endtask

    // Compare every output against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] eDout, input logic eDv,
                               input logic [1:0] eSlot, input logic eLocked, input logic eSerr);
        cmp({tag, ".dout"},       32'(bus.dout),       32'(eDout));
        cmp({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(eDv));
        cmp({tag, ".slot"},       32'(bus.slot),       32'(eSlot));
        cmp({tag, ".locked"},     32'(bus.locked),     32'(eLocked));
        cmp({tag, ".sync_err"},   32'(bus.sync_err),   32'(eSerr));
`ifdef TDM_PARITY_EN
        cmp({tag, ".par_err"},    32'(bus.par_err),    32'(expParErr));
`endif
    endtask

    initial begin
        rst            = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
`ifdef TDM_PARITY_EN
        bus.din_par    = 1'b0;
`endif
        #12;
        checkOutput("reset", 4'b0000, 0, 2'd0, 0, 0);
        rst = 1'b0;
        #5;

        // Basic frame 1,0,1,1.
        applyStimulus(1, 1, 1); checkOutput("f1.s0", 4'b0000, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("f1.s1", 4'b0000, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("f1.s2", 4'b0000, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("f1.s3", 4'b1101, 1, 2'd0, 1, 0);
        applyStimulus(0, 0, 0); checkOutput("f1.idle", 4'b1101, 0, 2'd0, 1, 0);

        // Same frame with a 3-cycle gap between slots 1 and 2.
        applyStimulus(1, 1, 1); checkOutput("f2.s0", 4'b1101, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("f2.s1", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(0, 0, 1); checkOutput("f2.gap0", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(0, 1, 0); checkOutput("f2.gap1", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(0, 0, 1); checkOutput("f2.gap2", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("f2.s2", 4'b1101, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("f2.s3", 4'b1101, 1, 2'd0, 1, 0);

        // Early sync at slot 2, then 1,1,1 on top of slot-0 din=0.
        applyStimulus(1, 1, 0); checkOutput("es.s0", 4'b1101, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("es.s1", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(1, 1, 0); checkOutput("es.sync", 4'b1101, 0, 2'd1, 1, 1);
        applyStimulus(1, 0, 1); checkOutput("es.r1", 4'b1101, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("es.r2", 4'b1101, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("es.r3", 4'b1110, 1, 2'd0, 1, 0);

        // Missing sync at slot 0 drops to HUNT.
        applyStimulus(1, 0, 1); checkOutput("ms.beat", 4'b1110, 0, 2'd0, 0, 1);
        applyStimulus(0, 0, 0); checkOutput("ms.idle", 4'b1110, 0, 2'd0, 0, 0);

        // Hunting: unsynced beats ignored, then frame 0,1,1,0.
        applyStimulus(1, 0, 1); checkOutput("hu.b0", 4'b1110, 0, 2'd0, 0, 0);
        applyStimulus(1, 0, 0); checkOutput("hu.b1", 4'b1110, 0, 2'd0, 0, 0);
        applyStimulus(1, 0, 1); checkOutput("hu.b2", 4'b1110, 0, 2'd0, 0, 0);
        applyStimulus(1, 0, 1); checkOutput("hu.b3", 4'b1110, 0, 2'd0, 0, 0);
        applyStimulus(1, 0, 0); checkOutput("hu.b4", 4'b1110, 0, 2'd0, 0, 0);
        applyStimulus(1, 1, 0); checkOutput("hu.s0", 4'b1110, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("hu.s1", 4'b1110, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("hu.s2", 4'b1110, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("hu.s3", 4'b0110, 1, 2'd0, 1, 0);

        // Reset after slot 2, then clean frame 1,1,0,0.
        applyStimulus(1, 1, 1); checkOutput("rs.s0", 4'b0110, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("rs.s1", 4'b0110, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("rs.s2", 4'b0110, 0, 2'd3, 1, 0);
        bus.din_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rs.async", 4'b0000, 0, 2'd0, 0, 0);
        #2;
        rst = 1'b0;
        applyStimulus(1, 1, 1); checkOutput("rs.f.s0", 4'b0000, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("rs.f.s1", 4'b0000, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("rs.f.s2", 4'b0000, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("rs.f.s3", 4'b0011, 1, 2'd0, 1, 0);

`ifdef TDM_PARITY_EN
        // Bad parity on slot 1: frame dropped, par_err pulses at the last slot.
        applyStimulus(1, 1, 1); checkOutput("pe.s0", 4'b0011, 0, 2'd1, 1, 0);
        parFlip = 1'b1;
        applyStimulus(1, 0, 0); checkOutput("pe.s1", 4'b0011, 0, 2'd2, 1, 0);
        parFlip = 1'b0;
        applyStimulus(1, 0, 1); checkOutput("pe.s2", 4'b0011, 0, 2'd3, 1, 0);
        expParErr = 1'b1;
        applyStimulus(1, 0, 1); checkOutput("pe.s3", 4'b0011, 0, 2'd0, 1, 0);
        expParErr = 1'b0;
        applyStimulus(1, 1, 0); checkOutput("pg.s0", 4'b0011, 0, 2'd1, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("pg.s1", 4'b0011, 0, 2'd2, 1, 0);
        applyStimulus(1, 0, 0); checkOutput("pg.s2", 4'b0011, 0, 2'd3, 1, 0);
        applyStimulus(1, 0, 1); checkOutput("pg.s3", 4'b1010, 1, 2'd0, 1, 0);
`endif

        applyStimulus(0, 0, 0); checkOutput("end.idle", 4'b0000 | bus.dout, 0, 2'd0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
